// File: rtl/gpio_input_debouncer.sv
// rtl/gpio_input_debouncer.sv - switch input synchroniser, per-bit debouncer, change strobes and sticky interrupt
module gpio_input_debouncer #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_async_i,
    input  logic             irq_en_i,
    input  logic             irq_clear_i,
    output logic [WIDTH-1:0] sw_stable_o,
    output logic [WIDTH-1:0] sw_changed_o,
    output logic [WIDTH-1:0] pending_o,
    output logic             irq_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        sync1_d   = sw_async_i;
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        changed_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // Any sample matching the stable value leaves the counter cleared.
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i]  = sync2_q[i];
                    changed_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // A new change on the clearing edge survives the clear.
        pending_d = (pending_q & ~{WIDTH{irq_clear_i}}) | changed_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            changed_q <= '0;
            pending_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            pending_q <= pending_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_stable_o  = stable_q;
    assign sw_changed_o = changed_q;
    assign pending_o    = pending_q;
    assign irq_o        = irq_en_i & (|pending_q);

endmodule
